// File: rtl/qdr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qdr_port_arbiter
// Purpose  : Round-robin sharing of a QDRII+ app_* port; in-order read tag FIFO
// Revision : 1.0
// ============================================================================
module qdr_port_arbiter #(
  parameter int NUM_CLIENTS    = 2,
  parameter int ADDR_WIDTH     = 18,
  parameter int APP_DATA_WIDTH = 144,
  parameter int APP_BW_WIDTH   = 16,
  parameter int RD_TAG_DEPTH   = 16
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst,
  input  logic                                init_calib_complete,
  input  logic [NUM_CLIENTS-1:0]              wr_req,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_CLIENTS*APP_DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_CLIENTS*APP_BW_WIDTH-1:0] wr_bw_n,
  output logic [NUM_CLIENTS-1:0]              wr_gnt,
  input  logic [NUM_CLIENTS-1:0]              rd_req,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_CLIENTS-1:0]              rd_gnt,
  output logic [NUM_CLIENTS-1:0]              rd_data_valid,
  output logic [APP_DATA_WIDTH-1:0]           rd_data,
  output logic                                app_wr_cmd,
  output logic [ADDR_WIDTH-1:0]               app_wr_addr,
  output logic [APP_DATA_WIDTH-1:0]           app_wr_data,
  output logic [APP_BW_WIDTH-1:0]             app_wr_bw_n,
  output logic                                app_rd_cmd,
  output logic [ADDR_WIDTH-1:0]               app_rd_addr,
  input  logic                                app_rd_valid,
  input  logic [APP_DATA_WIDTH-1:0]           app_rd_data,
  output logic [$clog2(RD_TAG_DEPTH):0]       rd_outstanding,
  output logic                                tag_err
);

  localparam int c_ptr_w  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int c_tag_aw = $clog2(RD_TAG_DEPTH);
  localparam int c_cnt_w  = c_tag_aw + 1;

  // First requester strictly after ptr, wrapping modulo NUM_CLIENTS.
  function automatic logic [NUM_CLIENTS-1:0] f_rr_pick(
    input logic [NUM_CLIENTS-1:0] req,
    input logic [c_ptr_w-1:0]     ptr
  );
    logic [NUM_CLIENTS-1:0] gnt;
    logic                   found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % NUM_CLIENTS))) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  logic [c_ptr_w-1:0]        r_wr_ptr;
  logic [c_ptr_w-1:0]        r_rd_ptr;
  logic [c_ptr_w-1:0]        r_tag_mem [RD_TAG_DEPTH];
  logic [c_tag_aw-1:0]       r_tag_wp;
  logic [c_tag_aw-1:0]       r_tag_rp;
  logic [c_cnt_w-1:0]        r_rd_cnt;
  logic                      r_tag_err;
  logic                      r_app_wr_cmd;
  logic [ADDR_WIDTH-1:0]     r_app_wr_addr;
  logic [APP_DATA_WIDTH-1:0] r_app_wr_data;
  logic [APP_BW_WIDTH-1:0]   r_app_wr_bw_n;
  logic                      r_app_rd_cmd;
  logic [ADDR_WIDTH-1:0]     r_app_rd_addr;
  logic [NUM_CLIENTS-1:0]    r_rd_dv;
  logic [APP_DATA_WIDTH-1:0] r_rd_data;

  logic [NUM_CLIENTS-1:0]    w_wr_gnt;
  logic [NUM_CLIENTS-1:0]    w_rd_gnt;
  logic [c_ptr_w-1:0]        w_wr_idx;
  logic [c_ptr_w-1:0]        w_rd_idx;
  logic [ADDR_WIDTH-1:0]     w_wr_addr_sel;
  logic [APP_DATA_WIDTH-1:0] w_wr_data_sel;
  logic [APP_BW_WIDTH-1:0]   w_wr_bw_sel;
  logic [ADDR_WIDTH-1:0]     w_rd_addr_sel;
  logic [NUM_CLIENTS-1:0]    w_head_oh;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_tag_room;

  assign w_tag_room = (r_rd_cnt < c_cnt_w'(RD_TAG_DEPTH));
  assign w_wr_gnt   = (sys_rst && init_calib_complete) ? f_rr_pick(wr_req, r_wr_ptr) : '0;
  assign w_rd_gnt   = (sys_rst && init_calib_complete && w_tag_room) ?
                      f_rr_pick(rd_req, r_rd_ptr) : '0;
  assign w_push     = |w_rd_gnt;
  assign w_pop      = app_rd_valid && (r_rd_cnt != '0);

  always_comb begin
    w_wr_idx      = '0;
    w_rd_idx      = '0;
    w_wr_addr_sel = '0;
    w_wr_data_sel = '0;
    w_wr_bw_sel   = '1;
    w_rd_addr_sel = '0;
    w_head_oh     = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_wr_gnt[i]) begin
        w_wr_idx      = c_ptr_w'(i);
        w_wr_addr_sel = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wr_data_sel = wr_data[i*APP_DATA_WIDTH +: APP_DATA_WIDTH];
        w_wr_bw_sel   = wr_bw_n[i*APP_BW_WIDTH +: APP_BW_WIDTH];
      end
      if (w_rd_gnt[i]) begin
        w_rd_idx      = c_ptr_w'(i);
        w_rd_addr_sel = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      w_head_oh[i] = (r_tag_mem[r_tag_rp] == c_ptr_w'(i));
    end
  end

  // Tag storage needs no reset: validity is defined by the pointers and count.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_tag_mem[r_tag_wp] <= w_rd_idx;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_wr_ptr      <= c_ptr_w'(NUM_CLIENTS-1);
      r_rd_ptr      <= c_ptr_w'(NUM_CLIENTS-1);
      r_tag_wp      <= '0;
      r_tag_rp      <= '0;
      r_rd_cnt      <= '0;
      r_tag_err     <= 1'b0;
      r_app_wr_cmd  <= 1'b0;
      r_app_wr_addr <= '0;
      r_app_wr_data <= '0;
      r_app_wr_bw_n <= '1;
      r_app_rd_cmd  <= 1'b0;
      r_app_rd_addr <= '0;
      r_rd_dv       <= '0;
      r_rd_data     <= '0;
    end else begin
      r_app_wr_cmd  <= |w_wr_gnt;
      r_app_wr_bw_n <= w_wr_bw_sel;
      if (|w_wr_gnt) begin
        r_wr_ptr      <= w_wr_idx;
        r_app_wr_addr <= w_wr_addr_sel;
        r_app_wr_data <= w_wr_data_sel;
      end
      r_app_rd_cmd <= w_push;
      if (w_push) begin
        r_rd_ptr      <= w_rd_idx;
        r_app_rd_addr <= w_rd_addr_sel;
        r_tag_wp      <= r_tag_wp + 1'b1;
      end
      r_rd_dv <= w_pop ? w_head_oh : '0;
      if (w_pop) begin
        r_rd_data <= app_rd_data;
        r_tag_rp  <= r_tag_rp + 1'b1;
      end
      if (app_rd_valid && (r_rd_cnt == '0)) begin
        r_tag_err <= 1'b1;
      end
      if (w_push && !w_pop) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_rd_cnt <= r_rd_cnt - 1'b1;
      end
    end
  end

  assign wr_gnt         = w_wr_gnt;
  assign rd_gnt         = w_rd_gnt;
  assign rd_data_valid  = r_rd_dv;
  assign rd_data        = r_rd_data;
  assign app_wr_cmd     = r_app_wr_cmd;
  assign app_wr_addr    = r_app_wr_addr;
  assign app_wr_data    = r_app_wr_data;
  assign app_wr_bw_n    = r_app_wr_bw_n;
  assign app_rd_cmd     = r_app_rd_cmd;
  assign app_rd_addr    = r_app_rd_addr;
  assign rd_outstanding = r_rd_cnt;
  assign tag_err        = r_tag_err;

endmodule
`default_nettype wire

// File: tb/tb_qdr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qdr_port_arbiter
// Purpose  : Directed, table-driven self-checking bench for qdr_port_arbiter
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_qdr_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 18;
  localparam int DW = 144;
  localparam int BW = 16;
  localparam int TD = 16;
  localparam int CW = 5;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b0;
  logic            init_calib_complete = 1'b0;
  logic [N-1:0]    wr_req = '0;
  logic [N-1:0]    rd_req = '0;
  logic [N*AW-1:0] wr_addr = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [N*BW-1:0] wr_bw_n = '1;
  logic [N-1:0]    wr_gnt, rd_gnt, rd_data_valid;
  logic [DW-1:0]   rd_data, app_wr_data;
  logic [DW-1:0]   app_rd_data = '0;
  logic            app_wr_cmd, app_rd_cmd, tag_err;
  logic            app_rd_valid = 1'b0;
  logic [AW-1:0]   app_wr_addr, app_rd_addr;
  logic [BW-1:0]   app_wr_bw_n;
  logic [CW-1:0]   rd_outstanding;

  int n_tests = 0;
  int n_fail  = 0;

  qdr_port_arbiter #(
    .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW),
    .APP_BW_WIDTH(BW), .RD_TAG_DEPTH(TD)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bw_n(wr_bw_n),
    .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .app_wr_cmd(app_wr_cmd), .app_wr_addr(app_wr_addr), .app_wr_data(app_wr_data),
    .app_wr_bw_n(app_wr_bw_n), .app_rd_cmd(app_rd_cmd), .app_rd_addr(app_rd_addr),
    .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data),
    .rd_outstanding(rd_outstanding), .tag_err(tag_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic         calib;
    logic [N-1:0] wr_req;
    logic [N-1:0] rd_req;
    logic [N-1:0] exp_wg;
    logic [N-1:0] exp_rg;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dword(input int k);
    return {36'hA00000000 + 36'(k), 36'h0000000BB, 36'h0000000CC, 36'h0000000D0 + 36'(k)};
  endfunction

  initial begin
    logic [N-1:0] prev_wg;
    logic [N-1:0] prev_rg;
    int           exp_out;
    int           gcnt;
    logic [N-1:0] rexp [4];

    // Write sequence starts at ptr=1 after gating ends on a client-1 grant.
    vecs[0] = '{1'b1, 2'b11, 2'b01, 2'b01, 2'b01};
    vecs[1] = '{1'b1, 2'b01, 2'b11, 2'b01, 2'b10};
    vecs[2] = '{1'b1, 2'b10, 2'b11, 2'b10, 2'b01};
    vecs[3] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00};
    vecs[4] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[5] = '{1'b1, 2'b11, 2'b10, 2'b01, 2'b10};
    vecs[6] = '{1'b1, 2'b11, 2'b00, 2'b10, 2'b00};

    // Reset state
    repeat (3) tick();
    #1;
    chk("rst_app_wr_cmd", app_wr_cmd, 1'b0);
    chk("rst_app_wr_bw_n", app_wr_bw_n, 16'hFFFF);
    chk("rst_app_wr_addr", app_wr_addr, '0);
    chk("rst_app_wr_data", app_wr_data, '0);
    chk("rst_app_rd_cmd", app_rd_cmd, 1'b0);
    chk("rst_rd_data_valid", rd_data_valid, '0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_rd_outstanding", rd_outstanding, '0);
    chk("rst_tag_err", tag_err, 1'b0);
    sys_rst = 1'b1;
    tick();

    // Calibration gating
    wr_req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("gated_wr_gnt", wr_gnt, 2'b00);
      chk("gated_app_wr_cmd", app_wr_cmd, 1'b0);
      tick();
    end
    init_calib_complete = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("alt_wr_gnt", wr_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt_app_wr_cmd", app_wr_cmd, (i != 0) ? 1'b1 : 1'b0);
      tick();
    end

    // Arbitration vectors
    prev_wg = 2'b10;
    prev_rg = 2'b00;
    exp_out = 0;
    for (int i = 0; i < 7; i++) begin
      init_calib_complete = vecs[i].calib;
      wr_req = vecs[i].wr_req;
      rd_req = vecs[i].rd_req;
      #1;
      chk("vec_wr_gnt", wr_gnt, vecs[i].exp_wg);
      chk("vec_rd_gnt", rd_gnt, vecs[i].exp_rg);
      chk("vec_app_wr_cmd", app_wr_cmd, |prev_wg);
      chk("vec_app_rd_cmd", app_rd_cmd, |prev_rg);
      chk("vec_rd_outstanding", rd_outstanding, CW'(exp_out));
      prev_wg = vecs[i].exp_wg;
      prev_rg = vecs[i].exp_rg;
      if (|vecs[i].exp_rg) exp_out++;
      tick();
    end
    init_calib_complete = 1'b1;
    wr_req = '0;
    rd_req = '0;
    tick();

    // Drain the four table reads (clients 0,1,0,1)
    rexp[0] = 2'b01; rexp[1] = 2'b10; rexp[2] = 2'b01; rexp[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      app_rd_valid = 1'b1;
      app_rd_data  = dword(100 + k);
      tick();
      #1;
      chk("drain_rd_data_valid", rd_data_valid, rexp[k]);
      chk("drain_rd_data", rd_data, dword(100 + k));
    end
    app_rd_valid = 1'b0;
    tick();
    chk("drain_rd_outstanding", rd_outstanding, '0);
    chk("drain_dv_idle", rd_data_valid, '0);

    // Read routing: clients 0,1,1,0
    rd_addr = {18'h20001, 18'h10000};
    rexp[0] = 2'b01; rexp[1] = 2'b10; rexp[2] = 2'b10; rexp[3] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      rd_req = rexp[k];
      #1;
      chk("route_rd_gnt", rd_gnt, rexp[k]);
      tick();
      #1;
      chk("route_app_rd_cmd", app_rd_cmd, 1'b1);
      chk("route_app_rd_addr", app_rd_addr, rexp[k][1] ? 18'h20001 : 18'h10000);
    end
    rd_req = '0;
    tick();
    chk("route_app_rd_cmd_idle", app_rd_cmd, 1'b0);
    for (int k = 0; k < 4; k++) begin
      app_rd_valid = 1'b1;
      app_rd_data  = dword(k);
      tick();
      app_rd_valid = 1'b0;
      app_rd_data  = '1;
      #1;
      chk("route_rd_data_valid", rd_data_valid, rexp[k]);
      chk("route_rd_data", rd_data, dword(k));
      tick();
      chk("route_dv_gap", rd_data_valid, '0);
      chk("route_rd_data_hold", rd_data, dword(k));
    end
    chk("route_rd_outstanding", rd_outstanding, '0);

    // Write data path
    wr_addr = {18'h00ABC, 18'h3FFFF};
    wr_data = {112'h123456789ABCDEF0123456789ABC, 32'hDEADBEEF, {DW{1'b1}}};
    wr_bw_n = {16'h00F0, 16'h0F0F};
    wr_req  = 2'b10;
    #1;
    chk("wp_wr_gnt", wr_gnt, 2'b10);
    tick();
    wr_req = '0;
    #1;
    chk("wp_app_wr_cmd", app_wr_cmd, 1'b1);
    chk("wp_app_wr_addr", app_wr_addr, 18'h00ABC);
    chk("wp_app_wr_bw_n", app_wr_bw_n, 16'h00F0);
    chk("wp_app_wr_data", app_wr_data, {112'h123456789ABCDEF0123456789ABC, 32'hDEADBEEF});
    tick();
    chk("wp_idle_cmd", app_wr_cmd, 1'b0);
    chk("wp_idle_bw_n", app_wr_bw_n, 16'hFFFF);

    // Tag full: client 0 reads with no returns
    rd_req = 2'b01;
    gcnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rd_gnt[0]) gcnt++;
      tick();
    end
    #1;
    chk("full_grant_count", gcnt, 16);
    chk("full_rd_outstanding", rd_outstanding, 5'd16);
    chk("full_rd_gnt", rd_gnt, 2'b00);
    app_rd_valid = 1'b1;
    app_rd_data  = dword(50);
    #1;
    chk("full_gnt_during_pop", rd_gnt, 2'b00);
    tick();
    app_rd_valid = 1'b0;
    #1;
    chk("full_pop_dv", rd_data_valid, 2'b01);
    gcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (rd_gnt[0]) gcnt++;
      tick();
      #1;
    end
    chk("refill_grant_count", gcnt, 1);
    chk("refill_rd_outstanding", rd_outstanding, 5'd16);

    // Simultaneous push and pop at rd_outstanding=5
    rd_req = '0;
    app_rd_valid = 1'b1;
    repeat (11) tick();
    chk("pp_pre_outstanding", rd_outstanding, 5'd5);
    rd_req = 2'b01;
    #1;
    chk("pp_rd_gnt", rd_gnt, 2'b01);
    tick();
    rd_req = '0;
    app_rd_valid = 1'b0;
    #1;
    chk("pp_outstanding", rd_outstanding, 5'd5);
    app_rd_valid = 1'b1;
    repeat (5) tick();
    app_rd_valid = 1'b0;
    chk("pp_drained", rd_outstanding, '0);
    tick();
    chk("pp_no_tag_err", tag_err, 1'b0);

    // Return with an empty tag FIFO
    app_rd_valid = 1'b1;
    tick();
    app_rd_valid = 1'b0;
    #1;
    chk("err_tag_err", tag_err, 1'b1);
    chk("err_rd_data_valid", rd_data_valid, '0);
    chk("err_rd_outstanding", rd_outstanding, '0);
    repeat (3) tick();
    chk("err_sticky", tag_err, 1'b1);

    // Reset clears everything and restores client-0 priority
    sys_rst = 1'b0;
    tick();
    #1;
    chk("rst2_tag_err", tag_err, 1'b0);
    chk("rst2_app_wr_cmd", app_wr_cmd, 1'b0);
    chk("rst2_app_rd_cmd", app_rd_cmd, 1'b0);
    chk("rst2_app_wr_bw_n", app_wr_bw_n, 16'hFFFF);
    chk("rst2_app_wr_addr", app_wr_addr, '0);
    chk("rst2_rd_data", rd_data, '0);
    chk("rst2_rd_data_valid", rd_data_valid, '0);
    chk("rst2_rd_outstanding", rd_outstanding, '0);
    chk("rst2_wr_gnt", wr_gnt, '0);
    sys_rst = 1'b1;
    wr_req  = 2'b11;
    rd_req  = 2'b11;
    #1;
    chk("rst2_first_wr_gnt", wr_gnt, 2'b01);
    chk("rst2_first_rd_gnt", rd_gnt, 2'b01);
    tick();
    wr_req = '0;
    rd_req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
